// File: rtl/seq_controller.sv
// Instruction-sequencing controller: fetches from a synchronous ROM, strobes each
// instruction to the datapath, resolves branches through a target LUT, stops on HALT or budget.
module seq_controller #(
  parameter int                 PC_W       = 8,
  parameter int                 INSTR_W    = 9,
  parameter int                 OPC_W      = 3,
  parameter logic [OPC_W-1:0]   HALT_OPC   = 3'b111,
  parameter logic [OPC_W-1:0]   BR_OPC     = 3'b110,
  parameter int                 LUT_DEPTH  = 16,
  parameter logic [PC_W-1:0]    START_ADDR = '0,
  parameter int                 MAX_CYCLES = 1024,
  parameter int                 CNT_W      = 16,
  localparam int                LUT_IDX_W  = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [PC_W-1:0]      instr_addr,
  input  logic [INSTR_W-1:0]   instr_data,
  output logic [INSTR_W-1:0]   instr_out,
  output logic                 exec_valid,
  input  logic                 branch_taken,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q;
  logic [CNT_W-1:0]     cycle_cnt_q, instr_cnt_q;
  logic                 timeout_q;
  logic [PC_W-1:0]      lut [LUT_DEPTH];

  logic [OPC_W-1:0]     opc;
  logic [LUT_IDX_W-1:0] idx;
  logic                 is_halt, br_take, running, launch, budget_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign opc     = instr_data[INSTR_W-1 -: OPC_W];
  assign idx     = instr_data[LUT_IDX_W-1:0];
  assign is_halt = (state_q == EXEC) && (opc == HALT_OPC);
  assign br_take = (opc == BR_OPC) && branch_taken;
  assign running = (state_q == FETCH) || (state_q == EXEC);
  assign launch  = ((state_q == IDLE) || (state_q == DONE)) && start;
  // The cycle being spent now is the one that brings the count to the budget.
  assign budget_hit = running && ((32'(cycle_cnt_q) + 32'd1) >= 32'(MAX_CYCLES));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; HALT takes priority over budget expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = FETCH;
      FETCH:      state_d = budget_hit ? DONE : EXEC;
      EXEC: begin
        if (is_halt || budget_hit) state_d = DONE;
        else                       state_d = FETCH;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    instr_addr  = pc_q;
    exec_valid  = (state_q == EXEC);
    instr_out   = (state_q == EXEC) ? instr_data : '0;
    busy        = running;
    done        = (state_q == DONE);
    timeout     = timeout_q;
    cycle_count = cycle_cnt_q;
    instr_count = instr_cnt_q;
  end

  // Program counter, run statistics and timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else if (launch) begin
      pc_q        <= START_ADDR;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else if (running) begin
      cycle_cnt_q <= sat_inc(cycle_cnt_q);
      if (budget_hit && !is_halt) timeout_q <= 1'b1;
      if (state_q == EXEC) begin
        instr_cnt_q <= sat_inc(instr_cnt_q);
        if (!is_halt) pc_q <= br_take ? lut[idx] : pc_q + 1'b1;
      end
    end
  end

  // Target LUT: combinational read sees the pre-write contents on a same-cycle write
  always_ff @(posedge clk) begin
    if (lut_we) lut[lut_waddr] <= lut_wdata;
  end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: one 8-bit-PC instance with a 20-cycle budget
// and one 4-bit-PC instance starting at 15 for PC wrap and restart.
module tb_seq_controller;

  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] HALT = 9'h1C0;
  localparam logic [8:0] BR   = 9'h180;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, branch_taken;
  logic        start, lut_we;
  logic [3:0]  lut_waddr;
  logic [7:0]  lut_wdata, instr_addr;
  logic [8:0]  instr_data, instr_out;
  logic        exec_valid, busy, done, timeout;
  logic [15:0] cycle_count, instr_count;

  logic        start_w, lut_we_w;
  logic [3:0]  lut_waddr_w, lut_wdata_w, instr_addr_w;
  logic [8:0]  instr_data_w, instr_out_w;
  logic        exec_valid_w, busy_w, done_w, timeout_w;
  logic [15:0] cycle_count_w, instr_count_w;

  logic [8:0] rom   [256];
  logic [8:0] rom_w [16];
  logic [7:0] ex_q [$];
  logic [7:0] exw_q [$];
  logic [7:0] exp_q [$];
  int n_vec = 0;
  int n_bad = 0;

  seq_controller #(.MAX_CYCLES(20)) u_dut (
    .clk(clk), .reset(reset), .start(start), .instr_addr(instr_addr),
    .instr_data(instr_data), .instr_out(instr_out), .exec_valid(exec_valid),
    .branch_taken(branch_taken), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  seq_controller #(.PC_W(4), .START_ADDR(4'd15)) u_wrap (
    .clk(clk), .reset(reset), .start(start_w), .instr_addr(instr_addr_w),
    .instr_data(instr_data_w), .instr_out(instr_out_w), .exec_valid(exec_valid_w),
    .branch_taken(branch_taken), .lut_we(lut_we_w), .lut_waddr(lut_waddr_w),
    .lut_wdata(lut_wdata_w), .busy(busy_w), .done(done_w), .timeout(timeout_w),
    .cycle_count(cycle_count_w), .instr_count(instr_count_w)
  );

  always_ff @(posedge clk) begin
    instr_data   <= rom[instr_addr];
    instr_data_w <= rom_w[instr_addr_w];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exec_valid === 1'b1) begin
      ex_q.push_back(instr_addr);
      check_eq("instr_out", 32'(instr_out), 32'(rom[instr_addr]));
    end
    if (exec_valid_w === 1'b1) begin
      exw_q.push_back({4'b0, instr_addr_w});
      check_eq("instr_out_w", 32'(instr_out_w), 32'(rom_w[instr_addr_w]));
    end
  end

  task automatic check_trace(input string tag, input bit w);
    logic [7:0] got [$];
    if (w) got = exw_q; else got = ex_q;
    check_eq({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_eq($sformatf("%s_addr%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic pulse_start(input bit w);
    @(posedge clk); #1;
    if (w) start_w = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_w = 1'b0;
  endtask

  task automatic wait_done(input bit w, input int lim, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i <= lim; i++) begin
      if ((w ? done_w : done) === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
    @(posedge clk); #1;
    lut_we = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_addr"},  32'(instr_addr), 32'd0);
    check_eq({tag, "_iout"},  32'(instr_out), 32'd0);
    check_eq({tag, "_exec"},  32'(exec_valid), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_done"},  32'(done), 32'd0);
    check_eq({tag, "_tmo"},   32'(timeout), 32'd0);
    check_eq({tag, "_cyc"},   32'(cycle_count), 32'd0);
    check_eq({tag, "_icnt"},  32'(instr_count), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_w = 1'b0; branch_taken = 1'b0;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    lut_we_w = 1'b0; lut_waddr_w = '0; lut_wdata_w = '0;
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    for (int i = 0; i < 16; i++) rom_w[i] = NOP;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("rst");
    check_eq("rst_w_addr", 32'(instr_addr_w), 32'd0);
    check_eq("rst_w_busy", 32'(busy_w), 32'd0);
    reset = 1'b0;

    // Straight line: NOP x4 then HALT
    rom[4] = HALT;
    ex_q.delete();
    pulse_start(1'b0);
    check_eq("lat_fetch_busy", 32'(busy), 32'd1);
    check_eq("lat_fetch_addr", 32'(instr_addr), 32'd0);
    check_eq("lat_fetch_exec", 32'(exec_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("lat_exec", 32'(exec_valid), 32'd1);
    wait_done(1'b0, 30, "line_done_wait");
    check_eq("line_tmo",  32'(timeout), 32'd0);
    check_eq("line_busy", 32'(busy), 32'd0);
    check_eq("line_icnt", 32'(instr_count), 32'd5);
    check_eq("line_cyc",  32'(cycle_count), 32'd10);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    check_trace("line", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("line_hold_done", 32'(done), 32'd1);
    check_eq("line_hold_icnt", 32'(instr_count), 32'd5);

    // Branch taken through LUT[2]=0x10
    rom[1] = BR | 9'd2;
    rom[8'h10] = HALT;
    lut_write(4'd2, 8'h10);
    branch_taken = 1'b1;
    ex_q.delete();
    pulse_start(1'b0);
    wait_done(1'b0, 30, "brt_done_wait");
    check_eq("brt_icnt", 32'(instr_count), 32'd3);
    check_eq("brt_cyc",  32'(cycle_count), 32'd6);
    exp_q = '{8'd0, 8'd1, 8'h10};
    check_trace("brt", 1'b0);

    // Branch not taken falls through
    branch_taken = 1'b0;
    ex_q.delete();
    pulse_start(1'b0);
    wait_done(1'b0, 30, "brn_done_wait");
    check_eq("brn_icnt", 32'(instr_count), 32'd5);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    check_trace("brn", 1'b0);

    // Timeout: tight self-loop at address 0
    rom[0] = BR | 9'd0;
    lut_write(4'd0, 8'h00);
    branch_taken = 1'b1;
    ex_q.delete();
    pulse_start(1'b0);
    wait_done(1'b0, 40, "tmo_done_wait");
    check_eq("tmo_flag", 32'(timeout), 32'd1);
    check_eq("tmo_cyc",  32'(cycle_count), 32'd20);
    check_eq("tmo_icnt", 32'(instr_count), 32'd10);
    exp_q = '{10{8'd0}};
    check_trace("tmo", 1'b0);
    pulse_start(1'b0);
    check_eq("tmo_restart_flag", 32'(timeout), 32'd0);
    check_eq("tmo_restart_cyc",  32'(cycle_count), 32'd0);
    check_eq("tmo_restart_done", 32'(done), 32'd0);
    wait_done(1'b0, 40, "tmo2_done_wait");

    // Async reset mid-run while address 3 is being fetched
    rom[0] = NOP; rom[1] = NOP;
    branch_taken = 1'b0;
    ex_q.delete();
    pulse_start(1'b0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (instr_addr === 8'd3) begin seen = 1'b1; break; end
        @(posedge clk); #1;
      end
      check_eq("arst_reach_addr3", 32'(seen), 32'd1);
    end
    #2 reset = 1'b1;
    #1;
    check_idle_zero("arst");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("arst_no_strobe", 32'(ex_q.size()), 32'd3);
    check_eq("arst_idle_busy", 32'(busy), 32'd0);
    ex_q.delete();
    pulse_start(1'b0);
    wait_done(1'b0, 30, "arst_done_wait");
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    check_trace("arst_rerun", 1'b0);

    // PC wrap 15 -> 0, then restart from DONE
    rom_w[0] = HALT;
    for (int r = 0; r < 2; r++) begin
      exw_q.delete();
      pulse_start(1'b1);
      check_eq($sformatf("wrap%0d_start_addr", r), 32'(instr_addr_w), 32'd15);
      check_eq($sformatf("wrap%0d_start_cyc", r),  32'(cycle_count_w), 32'd0);
      check_eq($sformatf("wrap%0d_start_icnt", r), 32'(instr_count_w), 32'd0);
      check_eq($sformatf("wrap%0d_start_done", r), 32'(done_w), 32'd0);
      wait_done(1'b1, 20, $sformatf("wrap%0d_done_wait", r));
      check_eq($sformatf("wrap%0d_tmo", r),  32'(timeout_w), 32'd0);
      check_eq($sformatf("wrap%0d_icnt", r), 32'(instr_count_w), 32'd2);
      check_eq($sformatf("wrap%0d_cyc", r),  32'(cycle_count_w), 32'd4);
      exp_q = '{8'd15, 8'd0};
      check_trace($sformatf("wrap%0d", r), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
# seq_controller

Parametrised instruction-sequencing controller for the TinyChip core; the next generation of the fixed-width `controller` block. Given a start pulse, it fetches instructions from a synchronous instruction ROM and presents each one to the datapath with a one-cycle execute strobe. It resolves branches through an internal target LUT and stops on a HALT opcode or a cycle-budget timeout, reporting done, timeout and run statistics.

## Interface
Parameters:
- PC_W, 8, program-counter and instruction-address width
- INSTR_W, 9, instruction width
- OPC_W, 3, opcode field width (instr[INSTR_W-1 -: OPC_W])
- HALT_OPC, 3'b111, halt opcode
- BR_OPC, 3'b110, conditional-branch opcode; LUT index = instr[LUT_IDX_W-1:0]
- LUT_DEPTH, 16, branch-target LUT entries; LUT_IDX_W = $clog2(LUT_DEPTH)
- START_ADDR, 0, PC value loaded on start
- MAX_CYCLES, 1024, run budget in cycles (>= 2)
- CNT_W, 16, statistics counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin run; sampled only in IDLE or DONE
- instr_addr  out  PC_W  ROM address, driven directly from PC register
- instr_data  in  INSTR_W  ROM read data, valid one cycle after instr_addr
- instr_out  out  INSTR_W  instruction presented to datapath (= instr_data in EXEC)
- exec_valid  out  1  one-cycle strobe, high in EXEC only
- branch_taken  in  1  datapath condition, sampled in EXEC of a BR_OPC instruction
- lut_we  in  1  LUT write enable
- lut_waddr  in  LUT_IDX_W  LUT write index
- lut_wdata  in  PC_W  LUT write data (branch target)
- busy  out  1  high in FETCH/EXEC
- done  out  1  high in DONE
- timeout  out  1  run ended by budget expiry; valid while done
- cycle_count  out  CNT_W  cycles spent in FETCH/EXEC this run
- instr_count  out  CNT_W  exec_valid strobes this run

## Operation
- States: IDLE, FETCH, EXEC, DONE. Reset -> IDLE.
- IDLE/DONE + start=1: pc<=START_ADDR, cycle_count<=0, instr_count<=0, timeout<=0, -> FETCH.
- FETCH: instr_addr=pc; -> EXEC.
- EXEC: exec_valid=1, instr_out=instr_data, instr_count+1. Next PC/state decided on opcode:
  - HALT_OPC: -> DONE, pc unchanged.
  - BR_OPC and branch_taken=1: pc<=lut[idx], -> FETCH.
  - otherwise (including BR_OPC with branch_taken=0): pc<=pc+1 modulo 2^PC_W (wraps all-ones->0), -> FETCH.
- Timeout: cycle_count increments every FETCH/EXEC cycle. If it reaches MAX_CYCLES, next state is DONE with timeout<=1, whether the current state is FETCH or EXEC. HALT in the same EXEC cycle wins: timeout=0.
- Counters saturate at 2^CNT_W-1 and hold their values in DONE until the next start.
- start in FETCH/EXEC is ignored. start held high in DONE restarts on every sampling edge.
- LUT: written any state when lut_we=1. Same-cycle write/read of the same index returns the old value. LUT contents are not cleared by reset or start.

## Timing
- Reset (async, immediate): state=IDLE, pc=0, instr_addr=0, instr_out=0, exec_valid=0, busy=0, done=0, timeout=0, cycle_count=0, instr_count=0. Assertion mid-run aborts with no further strobes. LUT contents are undefined after reset.
- start sampled high at edge t: FETCH from t+1 with instr_addr=START_ADDR; first exec_valid in cycle t+2.
- Throughput: 2 cycles per instruction. Branch-taken target appears on instr_addr in the FETCH cycle immediately after EXEC; there is no bubble.
- HALT in EXEC at cycle k: done=1, busy=0 from k+1; done is held until the next start or reset.

## Test plan
- Straight line: ROM[0..3]=NOP, ROM[4]=HALT, start pulse -> 5 exec_valid strobes at addrs 0..4; done=1, timeout=0, instr_count=5, cycle_count=10.
- Branch taken: LUT[2]=0x10, ROM[1]=BR idx 2, branch_taken=1 -> instr_addr sequence 0,1,0x10; ROM[0x10]=HALT -> instr_count=3.
- Branch not taken: same program, branch_taken=0 -> addr 2 follows 1.
- Timeout: MAX_CYCLES=20, ROM[0]=BR idx0, LUT[0]=0, taken=1 -> done with timeout=1, cycle_count=20, instr_count=10.
- Async reset asserted mid-run at addr 3 -> all outputs 0 within the same cycle; start after release runs from START_ADDR.
- Restart and wrap: PC_W=4, START_ADDR=15, ROM[15]=NOP, ROM[0]=HALT -> addrs 15,0; a second start from DONE clears the counters and repeats identically.
